// File: rtl/rr_trace_marshaller2_pkg.sv
// rr_trace_marshaller2_pkg: shared channel-width types and width helpers for the record-side merge tree
package rr_trace_marshaller2_pkg;
  localparam int RR_CHANNEL_WIDTH_BITS = 8;
  localparam int RR_MAX_CHANNELS = 16;
  typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;
  function automatic int DEF_SUM_WIDTH(rr_widths_t w);
    int s = 0;
    for (int i = 0; i < RR_MAX_CHANNELS; i++) s += int'(w[i]);
    return s;
  endfunction
  function automatic int DEF_GET_OFFSET(rr_widths_t w, int n);
    int s = 0;
    for (int i = 0; i < RR_MAX_CHANNELS; i++) if (i < n) s += int'(w[i]);
    return s;
  endfunction
  function automatic rr_widths_t rr_join2_widths(rr_widths_t a, rr_widths_t b, int na);
    return a | (b << (na * RR_CHANNEL_WIDTH_BITS));
  endfunction
endpackage

// File: rtl/rr_trace_marshaller2_if.sv
// rr_trace_marshaller2_if: packed replay record bus (valid/ready, per-channel valids, compacted payload, loge flags)
interface rr_trace_marshaller2_if import rr_trace_marshaller2_pkg::*; #(
  parameter int LOGB_CHANNEL_CNT = 1,
  parameter int LOGE_CHANNEL_CNT = 1,
  parameter rr_widths_t CHANNEL_WIDTHS = rr_widths_t'(8'd8)
);
  localparam int FULL_WIDTH = DEF_SUM_WIDTH(CHANNEL_WIDTHS);
  logic valid;
  logic ready;
  logic [LOGB_CHANNEL_CNT-1:0] logb_valid;
  logic [FULL_WIDTH-1:0] logb_data;
  logic [LOGE_CHANNEL_CNT-1:0] loge_valid;
  modport P (output valid, logb_valid, logb_data, loge_valid, input ready);
  modport C (input valid, logb_valid, logb_data, loge_valid, output ready);
endinterface

// File: rtl/rr_trace_marshaller2_join2.sv
// rr_trace_marshaller2_join2: lockstep join of two record buses plus stage-1 register with A payload length (checks under RR_TRACE_MARSHALLER_CHECK_EN)
module rr_trace_marshaller2_join2 import rr_trace_marshaller2_pkg::*; #(
  parameter int NA = 1,
  parameter int NB = 1,
  parameter int WA = 1,
  parameter int WB = 1,
  parameter int NE = 1,
  parameter int OW = 1,
  parameter rr_widths_t CW_A = '0
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
  , parameter rr_widths_t CW_B = '0
`endif
) (
  input  logic clk,
  input  logic rstn,
  rr_trace_marshaller2_if.C a,
  rr_trace_marshaller2_if.C b,
  input  logic s1_ready,
  output logic s1_valid,
  output logic [NA-1:0] a_lv,
  output logic [NB-1:0] b_lv,
  output logic [WA-1:0] a_data,
  output logic [WB-1:0] b_data,
  output logic [NE-1:0] loge,
  output logic [OW-1:0] len_a
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
  , output logic err
`endif
);
  logic live;
  logic fire;
  logic [OW-1:0] len_a_c;
  assign fire = a.valid & b.valid & s1_ready & live;
  assign a.ready = s1_ready & live & b.valid;
  assign b.ready = s1_ready & live & a.valid;
  // live keeps ready low while reset is held and for the first cycle after release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) live <= 1'b0;
    else live <= 1'b1;
  // width of A's compacted payload: sum of widths of its valid channels
  always_comb begin
    len_a_c = '0;
    for (int i = 0; i < NA; i++) if (a.logb_valid[i]) len_a_c = len_a_c + OW'(CW_A[i]);
  end
  // stage 1 captures both inputs together on a lockstep fire
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_valid <= 1'b0;
      a_lv <= '0;
      b_lv <= '0;
      a_data <= '0;
      b_data <= '0;
      loge <= '0;
      len_a <= '0;
    end else if (s1_ready) begin
      s1_valid <= fire;
      if (fire) begin
        a_lv <= a.logb_valid;
        b_lv <= b.logb_valid;
        a_data <= a.logb_data;
        b_data <= b.logb_data;
        loge <= a.loge_valid;
        len_a <= len_a_c;
      end
    end
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
  logic [OW-1:0] len_b_c;
  logic bad;
  // width of B's compacted payload, used only to detect stray bits above it
  always_comb begin
    len_b_c = '0;
    for (int i = 0; i < NB; i++) if (b.logb_valid[i]) len_b_c = len_b_c + OW'(CW_B[i]);
  end
  assign bad = (a.loge_valid != b.loge_valid) | (|(a.logb_data >> len_a_c)) | (|(b.logb_data >> len_b_c));
  // err is sticky until reset once a malformed pair is consumed
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err <= 1'b0;
    else if (fire && bad) err <= 1'b1;
`ifndef SYNTHESIS
  // simulation report of the offending pair
  always @(posedge clk)
    if (rstn && fire && bad) $error("malformed join: loge %h/%h data %h/%h", a.loge_valid, b.loge_valid, a.logb_data, b.logb_data);
`endif
`endif
endmodule

// File: rtl/rr_trace_marshaller2.sv
// rr_trace_marshaller2: 2:1 record merge node, B payload packed directly above A's; 2-cycle latency (err port with RR_TRACE_MARSHALLER_CHECK_EN)
module rr_trace_marshaller2 import rr_trace_marshaller2_pkg::*; (
  input logic clk,
  input logic rstn,
  rr_trace_marshaller2_if.C inA,
  rr_trace_marshaller2_if.C inB,
  rr_trace_marshaller2_if.P out
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
  , output logic err
`endif
);
  localparam int NA = $bits(inA.logb_valid);
  localparam int NB = $bits(inB.logb_valid);
  localparam int WA = $bits(inA.logb_data);
  localparam int WB = $bits(inB.logb_data);
  localparam int NE = $bits(inA.loge_valid);
  localparam int FW = $bits(out.logb_data);
  localparam int OW = $clog2(FW + 1);
  localparam rr_widths_t CWA = inA.CHANNEL_WIDTHS;
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
  localparam rr_widths_t CWB = inB.CHANNEL_WIDTHS;
`endif
  logic s1_valid, s1_ready, s2_valid, s2_ready;
  logic [NA-1:0] a_lv;
  logic [NB-1:0] b_lv;
  logic [WA-1:0] a_data;
  logic [WB-1:0] b_data;
  logic [NE-1:0] loge, s2_loge;
  logic [OW-1:0] len_a;
  logic [NA+NB-1:0] s2_lv;
  logic [FW-1:0] joined, s2_data;
  rr_trace_marshaller2_join2 #(
    .NA(NA), .NB(NB), .WA(WA), .WB(WB), .NE(NE), .OW(OW), .CW_A(CWA)
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
    , .CW_B(CWB)
`endif
  ) u_join (
    .clk(clk), .rstn(rstn), .a(inA), .b(inB), .s1_ready(s1_ready),
    .s1_valid(s1_valid), .a_lv(a_lv), .b_lv(b_lv), .a_data(a_data), .b_data(b_data),
    .loge(loge), .len_a(len_a)
`ifdef RR_TRACE_MARSHALLER_CHECK_EN
    , .err(err)
`endif
  );
  assign s2_ready = !s2_valid | out.ready;
  assign s1_ready = !s1_valid | s2_ready;
  assign joined = FW'(a_data) | (FW'(b_data) << len_a);
  // stage 2 holds the compacted output until the consumer takes it
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_lv <= '0;
      s2_data <= '0;
      s2_loge <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lv <= {b_lv, a_lv};
        s2_data <= joined;
        s2_loge <= loge;
      end
    end
  assign out.valid = s2_valid;
  assign out.logb_valid = s2_lv;
  assign out.logb_data = s2_data;
  assign out.loge_valid = s2_loge;
endmodule
